instr_fetch_queue: RTL and testbench

Instruction fetch front end for the single-cycle datapath. It sits between the program-counter/redirect logic and instruction memory. It issues sequential word-address reads to instruction memory, buffers the returned instructions in a small in-order queue, and delivers them to decode over a valid/ready handshake. On a jump or taken branch it flushes all younger work and drops any stale memory responses still in flight.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/ifq_fifo.sv | 55 +++++
 rtl/instr_fetch_queue.sv | 132 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package instr_fetch_pkg;

  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned DEFAULT_DEPTH      = 4;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // One buffered instruction with the word address it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Shift-register FIFO: the head lives in slot 0, so the output is a flop.
// Push and pop together are legal at any occupancy, including full.
module ifq_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;

  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_wr_idx;

  // Guard against underflow/overflow; a pop frees a slot for a same-cycle push.
  assign w_pop    = i_pop & (r_count != '0);
  assign w_push   = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);
  assign w_wr_idx = r_count - CNT_W'(w_pop);

  // Storage shift on pop, write at the first free slot after the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (w_push) r_mem[w_wr_idx[IDX_W-1:0]] <= i_data;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_data  = r_mem[0];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: credit-limited sequential fetch, in-order
// instruction buffer, and redirect handling that drains stale responses.
module instr_fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_addr
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = $bits(ifq_entry_t);

  fetch_state_t      r_state;
  logic [31:0]       r_fetch_addr;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_stale;
  logic              r_run;

  logic [CNT_W-1:0]  w_q_count;
  logic              w_q_empty;
  logic              w_q_full;
  ifq_entry_t        w_q_head;
  ifq_entry_t        w_q_in;
  logic [31:0]       w_af_head;
  logic [CNT_W-1:0]  w_af_count;
  logic              w_af_empty;
  logic              w_af_full;

  logic              w_credit;
  logic              w_req_hs;
  logic              w_live_resp;
  logic              w_pop;
  logic [CNT_W-1:0]  w_inflight;
  logic              w_unused_ok;

  // Request side: decoded from registered state only, so valid/addr hold while stalled.
  assign w_credit       = (SUM_W'(w_q_count) + SUM_W'(r_outstanding)) < SUM_W'(DEPTH);
  assign imem_req_valid = r_run & (r_state == FETCH) & w_credit & ~w_af_full;
  assign imem_req_addr  = r_fetch_addr;
  assign w_req_hs       = imem_req_valid & imem_req_ready;

  // A response is kept only in FETCH and never in a redirect cycle.
  assign w_live_resp = imem_resp_valid & ~redirect & (r_state == FETCH) & ~w_af_empty;

  // Requests still owed a response once a redirect lands (includes this cycle's traffic).
  assign w_inflight = r_outstanding + r_stale + CNT_W'(w_req_hs) - CNT_W'(imem_resp_valid);

  // Decode side.
  assign instr_valid = ~w_q_empty & ~redirect;
  assign w_pop       = instr_valid & instr_ready;
  assign instr_data  = w_q_head.data;
  assign instr_addr  = w_q_head.addr;
  assign w_q_in      = '{addr: w_af_head, data: imem_resp_data};

  assign w_unused_ok = ^{w_q_full, w_af_count};

  // Addresses of in-flight requests, oldest at the head.
  ifq_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (redirect),
    .i_push  (w_req_hs & ~redirect),
    .i_data  (r_fetch_addr),
    .i_pop   (w_live_resp),
    .o_data  (w_af_head),
    .o_empty (w_af_empty),
    .o_full  (w_af_full),
    .o_count (w_af_count)
  );

  // Returned instructions waiting for decode.
  ifq_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_entry_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (redirect),
    .i_push  (w_live_resp),
    .i_data  (w_q_in),
    .i_pop   (w_pop),
    .o_data  (w_q_head),
    .o_empty (w_q_empty),
    .o_full  (w_q_full),
    .o_count (w_q_count)
  );

  // Fetch FSM, fetch address and outstanding/stale bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= FETCH;
      r_fetch_addr  <= RESET_ADDR;
      r_outstanding <= '0;
      r_stale       <= '0;
      r_run         <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect) begin
        r_fetch_addr  <= redirect_addr;
        r_outstanding <= '0;
        r_stale       <= w_inflight;
        r_state       <= (w_inflight != '0) ? DRAIN : FETCH;
      end else begin
        case (r_state)
          FETCH: begin
            if (w_req_hs) r_fetch_addr <= r_fetch_addr + 32'd1;
            r_outstanding <= r_outstanding + CNT_W'(w_req_hs) - CNT_W'(w_live_resp);
          end
          DRAIN: begin
            if (imem_resp_valid) begin
              r_stale <= r_stale - CNT_W'(1);
              if (r_stale == CNT_W'(1)) r_state <= FETCH;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a fixed-latency memory responder.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;

  int          lat;
  logic        p_v [4];
  logic [31:0] p_a [4];

  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_addr   (redirect_addr),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_addr      (instr_addr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hA5A5_5A5A) + 32'h0013_0013;
  endfunction

  // Memory: fixed latency `lat`, in order, reset together with the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        p_v[i] <= 1'b0;
        p_a[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        p_v[i] <= p_v[i+1];
        p_a[i] <= p_a[i+1];
      end
      p_v[3] <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        p_v[lat-1] <= 1'b1;
        p_a[lat-1] <= imem_req_addr;
      end
    end
  end

  assign imem_resp_valid = p_v[0];
  assign imem_resp_data  = mem_word(p_a[0]);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Pops n instructions (instr_ready must be 1), expecting consecutive addresses.
  task automatic expect_stream(input string tag, input logic [31:0] start, input int n);
    logic [31:0] a;
    int          w;
    a = start;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!instr_valid && w < 20) begin
        tick();
        w++;
      end
      if (!instr_valid) begin
        check_eq({tag, "_timeout"}, 64'(instr_valid), 64'd1);
        return;
      end
      check_eq({tag, "_addr"}, 64'(instr_addr), 64'(a));
      check_eq({tag, "_data"}, 64'(instr_data), 64'(mem_word(a)));
      a = a + 32'd1;
      tick();
    end
  endtask

  // Sequencer
  initial begin
    int   cnt;
    int   waits;
    logic saw_iv;

    rst            = 1'b0;
    redirect       = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    lat            = 1;

    // Reset values and first request
    repeat (2) tick();
    check_eq("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check_eq("rst_instr_valid", 64'(instr_valid), 64'd0);
    check_eq("rst_instr_data", 64'(instr_data), 64'd0);
    check_eq("rst_instr_addr", 64'(instr_addr), 64'd0);
    check_eq("rst_req_addr", 64'(imem_req_addr), 64'd0);
    rst = 1'b1;
    tick();
    check_eq("first_req_valid", 64'(imem_req_valid), 64'd1);
    check_eq("first_req_addr", 64'(imem_req_addr), 64'd0);

    // Latency 1, both sides ready: one instruction per cycle
    instr_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      check_eq("t1_valid", 64'(instr_valid), 64'd1);
      check_eq("t1_addr", 64'(instr_addr), 64'(k));
      check_eq("t1_data", 64'(instr_data), 64'(mem_word(32'(k))));
      tick();
    end

    // Decode stalled: credit stops at DEPTH requests
    instr_ready = 1'b0;
    reset_dut();
    cnt = 0;
    repeat (12) begin
      tick();
      if (imem_req_valid && imem_req_ready) cnt++;
    end
    check_eq("t2_req_count", 64'(cnt), 64'd4);
    check_eq("t2_req_stopped", 64'(imem_req_valid), 64'd0);
    check_eq("t2_head_valid", 64'(instr_valid), 64'd1);
    check_eq("t2_head_addr", 64'(instr_addr), 64'd0);
    instr_ready = 1'b1;
    tick();
    check_eq("t2_resume_valid", 64'(imem_req_valid), 64'd1);
    check_eq("t2_resume_addr", 64'(imem_req_addr), 64'd4);
    expect_stream("t2_stream", 32'd1, 6);

    // Memory backpressure holds request at addr 7
    reset_dut();
    waits = 0;
    while (!(imem_req_valid && imem_req_addr == 32'd7) && waits < 30) begin
      tick();
      waits++;
    end
    check_eq("t3_reach7", 64'(imem_req_addr), 64'd7);
    imem_req_ready = 1'b0;
    repeat (5) begin
      tick();
      check_eq("t3_hold_valid", 64'(imem_req_valid), 64'd1);
      check_eq("t3_hold_addr", 64'(imem_req_addr), 64'd7);
    end
    imem_req_ready = 1'b1;
    tick();
    check_eq("t3_next_valid", 64'(imem_req_valid), 64'd1);
    check_eq("t3_next_addr", 64'(imem_req_addr), 64'd8);

    // Latency 3, redirect with 2 outstanding
    lat = 3;
    reset_dut();
    repeat (3) tick();
    redirect       = 1'b1;
    redirect_addr  = 32'h100;
    imem_req_ready = 1'b0;
    tick();
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    check_eq("t4_drain_noreq", 64'(imem_req_valid), 64'd0);
    waits  = 0;
    saw_iv = 1'b0;
    while (!imem_req_valid && waits < 10) begin
      if (instr_valid) saw_iv = 1'b1;
      tick();
      waits++;
    end
    check_eq("t4_drain_cycles", 64'(waits), 64'd2);
    check_eq("t4_new_addr", 64'(imem_req_addr), 64'h100);
    check_eq("t4_no_instr", 64'(saw_iv), 64'd0);
    expect_stream("t4_stream", 32'h100, 3);

    // Redirect alongside a response, then again during DRAIN
    reset_dut();
    repeat (4) tick();
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_addr  = 32'h200;
    tick();
    check_eq("t5_drain_noreq", 64'(imem_req_valid), 64'd0);
    redirect_addr = 32'h300;
    tick();
    redirect = 1'b0;
    waits    = 0;
    saw_iv   = 1'b0;
    while (!imem_req_valid && waits < 10) begin
      if (instr_valid) saw_iv = 1'b1;
      tick();
      waits++;
    end
    check_eq("t5_drain_cycles", 64'(waits), 64'd1);
    check_eq("t5_new_addr", 64'(imem_req_addr), 64'h300);
    check_eq("t5_no_instr", 64'(saw_iv), 64'd0);
    imem_req_ready = 1'b1;
    expect_stream("t5_stream", 32'h300, 3);

    // Redirect with nothing in flight, address wrap
    lat            = 1;
    imem_req_ready = 1'b0;
    reset_dut();
    tick();
    redirect      = 1'b1;
    redirect_addr = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check_eq("t6_req_valid", 64'(imem_req_valid), 64'd1);
    check_eq("t6_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFF);
    imem_req_ready = 1'b1;
    tick();
    check_eq("t6_wrap_addr", 64'(imem_req_addr), 64'd0);
    expect_stream("t6_stream", 32'hFFFF_FFFF, 3);

    // Asynchronous reset mid-stream
    lat         = 3;
    instr_ready = 1'b0;
    reset_dut();
    repeat (5) tick();
    check_eq("t7_pre_valid", 64'(instr_valid), 64'd1);
    rst = 1'b0;
    #1;
    check_eq("t7_req_valid", 64'(imem_req_valid), 64'd0);
    check_eq("t7_instr_valid", 64'(instr_valid), 64'd0);
    check_eq("t7_instr_data", 64'(instr_data), 64'd0);
    check_eq("t7_instr_addr", 64'(instr_addr), 64'd0);
    check_eq("t7_req_addr", 64'(imem_req_addr), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("t7_restart_valid", 64'(imem_req_valid), 64'd1);
    check_eq("t7_restart_addr", 64'(imem_req_addr), 64'd0);
    instr_ready = 1'b1;
    expect_stream("t7_stream", 32'd0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
